rank_responder: RTL and testbench

- Per-node responder stage that sits directly downstream of the request-network router port and upstream of the response-network router port.
- Buffers incoming page-rank request flits and issues one query at a time to the local ant/page store.
- Matches the store's reply, saturates and packs the value into a response flit, and writes that flit into the response router under full/almost-full backpressure.
- One instance per node; four per NoC.

---
 rtl/rank_responder.sv | 172 +++++++++++++++++
 tb/tb_rank_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rank_responder.sv
// Per-node page-rank responder: buffers request flits, queries the local store
// one page at a time and writes a saturated response flit into the response router.
module rank_responder #(
    parameter logic [1:0]  NODE_ID    = 2'd0,
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned REQ_W      = 12,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_write,
    input  logic [REQ_W-1:0] req_data,
    output logic             req_full,
    output logic             req_almost_full,
    output logic [5:0]       query_id,
    output logic             query_valid,
    input  logic [28:0]      reply,
    input  logic             rsp_full,
    input  logic             rsp_almost_full,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_write,
    output logic             timeout_err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TMO_W = 4;
    localparam int unsigned ENT_W = 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_QUERY = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;

    logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [ENT_W-1:0] w_head;
    logic             w_push;
    logic             w_pop;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [1:0]       r_src;
    logic [1:0]       w_src_nxt;
    logic [TMO_W-1:0] r_cnt;
    logic [TMO_W-1:0] w_cnt_nxt;
    logic [5:0]       w_qid_nxt;
    logic             w_qv_nxt;
    logic [WIDTH-1:0] w_rsp_data_nxt;
    logic             w_rsp_write_nxt;
    logic             w_tmo_nxt;
    logic             w_match;
    logic             w_unused;

    assign w_unused = ^{req_data[7:6], reply[21:16]};

    function automatic logic [13:0] f_sat(input logic [15:0] v);
        return (v[15:14] == 2'b00) ? v[13:0] : 14'h3FFF;
    endfunction

    // Only flits addressed to this node enter the buffer; src and page id are kept.
    assign w_push  = req_write && (r_count != CNT_W'(FIFO_DEPTH)) && (req_data[9:8] == NODE_ID);
    assign w_head  = r_mem[r_rd_ptr];
    assign w_match = reply[28] && (reply[27:22] == query_id);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {req_data[11:10], req_data[5:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            req_full        <= 1'b0;
            req_almost_full <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count         <= w_count_nxt;
            req_full        <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
            req_almost_full <= (w_count_nxt >= CNT_W'(FIFO_DEPTH - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // The first QUERY cycle raises query_valid; replies are only matched afterwards.
    always_comb begin
        w_state_nxt     = r_state;
        w_pop           = 1'b0;
        w_src_nxt       = r_src;
        w_qid_nxt       = query_id;
        w_qv_nxt        = query_valid;
        w_cnt_nxt       = r_cnt;
        w_rsp_data_nxt  = rsp_data;
        w_rsp_write_nxt = 1'b0;
        w_tmo_nxt       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((r_count != '0) && !rsp_almost_full) begin
                    w_pop       = 1'b1;
                    w_src_nxt   = w_head[7:6];
                    w_qid_nxt   = w_head[5:0];
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_QUERY;
                end
            end
            S_QUERY: begin
                if (!query_valid) begin
                    w_qv_nxt = 1'b1;
                end else if (w_match) begin
                    w_qv_nxt       = 1'b0;
                    w_rsp_data_nxt = WIDTH'({r_src, f_sat(reply[15:0])});
                    w_state_nxt    = S_SEND;
                end else if (r_cnt == TMO_W'(TIMEOUT - 1)) begin
                    w_qv_nxt       = 1'b0;
                    w_tmo_nxt      = 1'b1;
                    w_rsp_data_nxt = WIDTH'({r_src, 14'h0000});
                    w_state_nxt    = S_SEND;
                end else begin
                    w_cnt_nxt = r_cnt + TMO_W'(1);
                end
            end
            S_SEND: begin
                if (!rsp_full) begin
                    w_rsp_write_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_src       <= '0;
            r_cnt       <= '0;
            query_id    <= '0;
            query_valid <= 1'b0;
            rsp_data    <= '0;
            rsp_write   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            r_src       <= w_src_nxt;
            r_cnt       <= w_cnt_nxt;
            query_id    <= w_qid_nxt;
            query_valid <= w_qv_nxt;
            rsp_data    <= w_rsp_data_nxt;
            rsp_write   <= w_rsp_write_nxt;
            timeout_err <= w_tmo_nxt;
        end
    end

endmodule

// File: tb/tb_rank_responder.sv
// Directed bench for rank_responder: latency, saturation, backpressure,
// timeout, response stall and reset abandonment.
module tb_rank_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_write;
    logic [11:0] req_data;
    logic        req_full;
    logic        req_almost_full;
    logic [5:0]  query_id;
    logic        query_valid;
    logic [28:0] reply;
    logic        rsp_full;
    logic        rsp_almost_full;
    logic [15:0] rsp_data;
    logic        rsp_write;
    logic        timeout_err;

    logic        auto_rep;
    logic [28:0] man_reply;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Store model: when enabled, answers every query with value 16'h1000 + page.
    assign reply = auto_rep ? {query_valid, query_id, 6'd0, 16'h1000 + 16'(query_id)} : man_reply;

    rank_responder #(
        .NODE_ID   (2'd0),
        .WIDTH     (16),
        .REQ_W     (12),
        .FIFO_DEPTH(4),
        .TIMEOUT   (15)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_write      (req_write),
        .req_data       (req_data),
        .req_full       (req_full),
        .req_almost_full(req_almost_full),
        .query_id       (query_id),
        .query_valid    (query_valid),
        .reply          (reply),
        .rsp_full       (rsp_full),
        .rsp_almost_full(rsp_almost_full),
        .rsp_data       (rsp_data),
        .rsp_write      (rsp_write),
        .timeout_err    (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [11:0] d);
        req_write = 1'b1;
        req_data  = d;
        tick();
        req_write = 1'b0;
        req_data  = '0;
    endtask

    task automatic wait_qv(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (query_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (rsp_write) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          ok;
        int          n_rsp;
        int          tmo_at;
        int          seen;
        logic [15:0] rsp_q [8];

        reset           = 1'b0;
        req_write       = 1'b0;
        req_data        = '0;
        rsp_full        = 1'b0;
        rsp_almost_full = 1'b0;
        auto_rep        = 1'b0;
        man_reply       = '0;
        tick();
        tick();
        check("rst_query_valid", 32'(query_valid), 32'd0);
        check("rst_query_id", 32'(query_id), 32'd0);
        check("rst_rsp_write", 32'(rsp_write), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_flags", 32'({req_full, req_almost_full, timeout_err}), 32'd0);
        reset = 1'b1;
        tick();

        // Exact latency: push at edge 0, query after edge 2, response one edge after match.
        push({2'd1, 2'd0, 2'd0, 6'd17});
        check("lat_qv_e0", 32'(query_valid), 32'd0);
        tick();
        check("lat_qv_e1", 32'(query_valid), 32'd0);
        tick();
        check("lat_qv_e2", 32'(query_valid), 32'd1);
        check("lat_qid", 32'(query_id), 32'd17);
        man_reply = {1'b1, 6'd17, 6'd0, 16'h0123};
        tick();
        man_reply = '0;
        check("lat_match_qv", 32'(query_valid), 32'd0);
        check("lat_match_wr", 32'(rsp_write), 32'd0);
        tick();
        check("lat_rsp_write", 32'(rsp_write), 32'd1);
        check("lat_rsp_data", 32'(rsp_data), 32'h4123);
        tick();
        check("lat_rsp_pulse", 32'(rsp_write), 32'd0);

        // Saturation.
        push({2'd3, 2'd0, 2'd0, 6'd5});
        wait_qv(ok);
        check("sat_qv_seen", 32'(ok), 32'd1);
        check("sat_qid", 32'(query_id), 32'd5);
        man_reply = {1'b1, 6'd5, 6'd0, 16'h8001};
        wait_rsp(ok);
        man_reply = '0;
        check("sat_rsp_seen", 32'(ok), 32'd1);
        check("sat_rsp_data", 32'(rsp_data), 32'hFFFF);
        tick();

        // Buffer fill while the response side is almost full.
        rsp_almost_full = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            push({2'd2, 2'd0, 2'd0, 6'(i)});
            if (i == 2) check("fill2_almost", 32'(req_almost_full), 32'd0);
            if (i == 3) check("fill3_almost", 32'(req_almost_full), 32'd1);
            if (i == 3) check("fill3_full", 32'(req_full), 32'd0);
            if (i == 4) check("fill4_full", 32'(req_full), 32'd1);
            if (i == 5) check("fill5_full", 32'(req_full), 32'd1);
        end
        tick();
        tick();
        check("fill_no_query", 32'(query_valid), 32'd0);
        auto_rep        = 1'b1;
        rsp_almost_full = 1'b0;
        n_rsp           = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (rsp_write) begin
                if (n_rsp < 8) rsp_q[n_rsp] = rsp_data;
                n_rsp++;
            end
        end
        check("fill_rsp_count", 32'(n_rsp), 32'd4);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("fill_rsp%0d", j), 32'(rsp_q[j]), 32'h9000 + 32'(j + 1));
        end
        check("fill_empty_flags", 32'({req_full, req_almost_full}), 32'd0);
        auto_rep = 1'b0;

        // Timeout, with a non-matching valid reply during the wait.
        push({2'd1, 2'd0, 2'd0, 6'd9});
        wait_qv(ok);
        check("tmo_qv_seen", 32'(ok), 32'd1);
        tmo_at = 0;
        seen   = 0;
        for (int c = 1; c <= 40; c++) begin
            man_reply = (c <= 5) ? {1'b1, 6'd10, 6'd0, 16'h0055} : '0;
            tick();
            if (rsp_write) seen++;
            if (c == 5) check("tmo_nomatch_qv", 32'(query_valid), 32'd1);
            if (timeout_err) begin
                tmo_at = c;
                break;
            end
        end
        man_reply = '0;
        check("tmo_cycle", 32'(tmo_at), 32'd15);
        check("tmo_early_wr", 32'(seen), 32'd0);
        check("tmo_exclusive", 32'(rsp_write), 32'd0);
        tick();
        check("tmo_rsp_write", 32'(rsp_write), 32'd1);
        check("tmo_rsp_data", 32'(rsp_data), 32'h4000);
        check("tmo_pulse", 32'(timeout_err), 32'd0);
        tick();

        // Response stall.
        auto_rep = 1'b1;
        rsp_full = 1'b1;
        push({2'd3, 2'd0, 2'd0, 6'd7});
        wait_qv(ok);
        check("stall_qv_seen", 32'(ok), 32'd1);
        tick();
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (rsp_write || rsp_data != 16'hD007) seen++;
        end
        check("stall_hold", 32'(seen), 32'd0);
        rsp_full = 1'b0;
        tick();
        check("stall_rsp_write", 32'(rsp_write), 32'd1);
        check("stall_rsp_data", 32'(rsp_data), 32'hD007);
        tick();
        check("stall_pulse", 32'(rsp_write), 32'd0);

        // Foreign destination is ignored.
        push({2'd1, 2'd2, 2'd0, 6'd3});
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (query_valid || rsp_write) seen++;
        end
        check("foreign_ignored", 32'(seen), 32'd0);

        // Reset during QUERY abandons the query and flushes the buffer.
        auto_rep  = 1'b0;
        man_reply = '0;
        push({2'd1, 2'd0, 2'd0, 6'd20});
        push({2'd2, 2'd0, 2'd0, 6'd21});
        wait_qv(ok);
        check("rstq_qv_seen", 32'(ok), 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rstq_query_valid", 32'(query_valid), 32'd0);
        check("rstq_query_id", 32'(query_id), 32'd0);
        check("rstq_fifo_flags", 32'({req_full, req_almost_full}), 32'd0);
        auto_rep = 1'b1;
        seen     = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (query_valid || rsp_write || timeout_err) seen++;
        end
        check("rstq_no_activity", 32'(seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
